// File: rtl/c3_pool_window_packer.sv
// c3_pool_window_packer
//   Producer side of the C3 pooling interface. Takes 16ch x 8b conv pixels in
//   raster order. It keeps the even rows in a line buffer and the odd-row
//   even-column pixel in a hold register. On each odd/odd pixel it emits a 2x2
//   window. Each channel's window is packed as {TL,TR,BL,BR}.
// Ports
//   clk, rst        clock; synchronous active-high reset
//   c3_frame_start  pulse, forces the current/next pixel position to (0,0)
//   c3_conv_valid   pixel present on c3_conv_in
//   c3_conv_in      ch k at [8k+7:8k]
//   c3_reg_valid    1-cycle pulse, window on c3_reg_out (1 clk after accept)
//   c3_reg_out      ch k at [32k+31:32k] = {TL,TR,BL,BR}; held between pulses
//   c3_frame_done   coincident with the last full window of the frame

// Per-channel slice: line buffer, bottom-left hold and output word.
module c3_pool_lane #(
  parameter int MAP_W = 10,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          buf_we,
  input  logic          hold_we,
  input  logic          fire,
  input  logic [CW-1:0] col,
  input  logic [7:0]    din,
  output logic [31:0]   word
);
  logic [MAP_W-1:0][7:0] line_buf;
  logic [7:0]            hold;
  logic [CW-1:0]         col_left;

  // fire only happens on odd columns, so the left neighbour is col with bit 0 cleared
  assign col_left = col & ~CW'(1);

  // storage carries no reset: every entry is rewritten before it is read
  always_ff @(posedge clk) begin
    if (buf_we)  line_buf[col] <= din;
    if (hold_we) hold          <= din;
  end

  always_ff @(posedge clk) begin
    if (rst)       word <= '0;
    else if (fire) word <= {line_buf[col_left], line_buf[col], hold, din};
  end
endmodule

module c3_pool_window_packer #(
  parameter int MAP_W = 10,
  parameter int MAP_H = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         c3_frame_start,
  input  logic         c3_conv_valid,
  input  logic [127:0] c3_conv_in,
  output logic         c3_reg_valid,
  output logic [511:0] c3_reg_out,
  output logic         c3_frame_done
);
  localparam int NUM_LANES = 16;
  localparam int VEC_W     = 8;
  localparam int STAGES    = 0;
  localparam int CW        = $clog2(MAP_W);
  localparam int RW        = $clog2(MAP_H);
  localparam logic [CW-1:0] COL_LAST = CW'(MAP_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(MAP_H - 1);
  // last emitted window position; a trailing odd column/row is never emitted
  localparam logic [CW-1:0] COL_WIN  = CW'(2 * (MAP_W / 2) - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(2 * (MAP_H / 2) - 1);

  logic [NUM_LANES-1:0][VEC_W-1:0]   px;
  logic [NUM_LANES-1:0][4*VEC_W-1:0] words;
  logic [CW-1:0] col, col_eff, col_nxt;
  logic [RW-1:0] row, row_eff, row_nxt;
  logic          buf_we, hold_we, fire, last;
  logic [STAGES:0] vld_pipe;
  logic            done_q;

  assign px         = c3_conv_in;
  assign c3_reg_out = words;

  // frame_start makes this cycle's pixel (if any) position (0,0)
  assign col_eff = c3_frame_start ? '0 : col;
  assign row_eff = c3_frame_start ? '0 : row;

  assign buf_we  = c3_conv_valid & ~rst & ~row_eff[0];
  assign hold_we = c3_conv_valid & ~rst &  row_eff[0] & ~col_eff[0];
  assign fire    = c3_conv_valid & ~rst &  row_eff[0] &  col_eff[0];
  assign last    = fire & (row_eff == ROW_WIN) & (col_eff == COL_WIN);

  always_comb begin
    col_nxt = col_eff;
    row_nxt = row_eff;
    if (c3_conv_valid) begin
      if (col_eff == COL_LAST) begin
        col_nxt = '0;
        row_nxt = (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
      end else begin
        col_nxt = col_eff + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      vld_pipe <= '0;
      done_q   <= 1'b0;
    end else begin
      col      <= col_nxt;
      row      <= row_nxt;
      vld_pipe <= fire;
      done_q   <= last;
    end
  end

  assign c3_reg_valid  = vld_pipe[STAGES];
  assign c3_frame_done = done_q;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    c3_pool_lane #(.MAP_W(MAP_W), .CW(CW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .buf_we  (buf_we),
      .hold_we (hold_we),
      .fire    (fire),
      .col     (col_eff),
      .din     (px[k]),
      .word    (words[k])
    );
  end
endmodule

// File: tb/tb_c3_pool_window_packer.sv
// Directed bench for c3_pool_window_packer: a 10x10 instance and a 9x9 instance.
// Pixel ch k at (r,c) = (10r+c+k) mod 256; expected windows come from that formula.
module tb_c3_pool_window_packer;
  typedef struct {
    int           cyc;
    logic [511:0] w;
    logic         done;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         fs  [2];
  logic         cv  [2];
  logic [127:0] cin [2];
  logic         rv  [2];
  logic [511:0] rout[2];
  logic         fd  [2];

  exp_t q0[$];
  exp_t q1[$];
  exp_t e_mon;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   nv[2]  = '{0, 0};
  int   nd[2]  = '{0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  c3_pool_window_packer #(.MAP_W(10), .MAP_H(10)) u_dut10 (
    .clk(clk), .rst(rst), .c3_frame_start(fs[0]), .c3_conv_valid(cv[0]),
    .c3_conv_in(cin[0]), .c3_reg_valid(rv[0]), .c3_reg_out(rout[0]),
    .c3_frame_done(fd[0]));

  c3_pool_window_packer #(.MAP_W(9), .MAP_H(9)) u_dut9 (
    .clk(clk), .rst(rst), .c3_frame_start(fs[1]), .c3_conv_valid(cv[1]),
    .c3_conv_in(cin[1]), .c3_reg_valid(rv[1]), .c3_reg_out(rout[1]),
    .c3_frame_done(fd[1]));

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pix(input int r, input int c);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = 8'((10*r + c + k) % 256);
    return v;
  endfunction

  function automatic logic [511:0] win(input int r, input int c);
    logic [511:0] v;
    logic [127:0] tl, tr, bl, br;
    tl = pix(r-1, c-1); tr = pix(r-1, c); bl = pix(r, c-1); br = pix(r, c);
    for (int k = 0; k < 16; k++)
      v[32*k +: 32] = {tl[8*k +: 8], tr[8*k +: 8], bl[8*k +: 8], br[8*k +: 8]};
    return v;
  endfunction

  // Every output pulse must match the oldest outstanding window, in order and on time.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rv[i]) begin
        nv[i]++;
        if (fd[i]) nd[i]++;
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          chk("unexp_vld", rv[i], 1'b0);
        end else begin
          if (i == 0) e_mon = q0.pop_front(); else e_mon = q1.pop_front();
          chk("latency", cyc, e_mon.cyc);
          chk("word", rout[i], e_mon.w);
          chk("done", fd[i], e_mon.done);
        end
      end else if (fd[i]) begin
        chk("done_novld", fd[i], 1'b0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_pix(input int id, input int r, input int c, input int w,
                           input int h, input bit start);
    exp_t e;
    cv[id] = 1'b1; cin[id] = pix(r, c); fs[id] = start;
    if (r % 2 == 1 && c % 2 == 1 && r < 2*(h/2) && c < 2*(w/2)) begin
      e.cyc  = cyc + 1;
      e.w    = win(r, c);
      e.done = (r == 2*(h/2) - 1) && (c == 2*(w/2) - 1);
      if (id == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk); #1;
    cv[id] = 1'b0; fs[id] = 1'b0;
  endtask

  task automatic send(input int id, input int w, input int h, input int p0, input int p1,
                      input int gap, input bit fs_first);
    for (int p = p0; p <= p1; p++) begin
      if (gap > 0) idle($urandom_range(0, gap));
      drive_pix(id, p / w, p % w, w, h, fs_first && p == p0);
    end
  endtask

  // One frame on a DUT, then its pulse/done counts.
  task automatic frame(input int id, input int w, input int h, input int gap,
                       input bit fs_first, input int n_win);
    int v0, d0;
    v0 = nv[id]; d0 = nd[id];
    send(id, w, h, 0, w*h - 1, gap, fs_first);
    idle(2);
    chk("n_valid", nv[id] - v0, n_win);
    chk("n_done", nd[id] - d0, 1);
    chk("q_empty", (id == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin cv[i] = 1'b0; fs[i] = 1'b0; cin[i] = '0; end
    idle(2);
    chk("rst_vld", rv[0], 1'b0);
    chk("rst_done", fd[0], 1'b0);
    chk("rst_out", rout[0], '0);
    chk("rst_out9", rout[1], '0);
    rst = 1'b0;
    idle(1);

    // 1: basic frame, with hand values on the first and last windows
    send(0, 10, 10, 0, 11, 0, 1'b0);
    idle(2);
    chk("first_ch0", rout[0][31:0], 32'h00010A0B);
    chk("first_ch15", rout[0][511:480], 32'h0F10191A);
    chk("hold_vld", rv[0], 1'b0);
    send(0, 10, 10, 12, 99, 0, 1'b0);
    idle(2);
    chk("last_ch0", rout[0][31:0], 32'h58596263);
    chk("t1_nvalid", nv[0], 25);
    chk("t1_ndone", nd[0], 1);

    // 2: random bubbles
    frame(0, 10, 10, 3, 1'b0, 25);

    // 3: reset mid-frame; the odd/odd pixel offered with rst must be dropped
    send(0, 10, 10, 0, 38, 0, 1'b0);
    rst = 1'b1; cv[0] = 1'b1; cin[0] = pix(3, 9);
    idle(1);
    rst = 1'b0; cv[0] = 1'b0;
    chk("rst_squash", rv[0], 1'b0);
    chk("rst_clear", rout[0], '0);
    frame(0, 10, 10, 0, 1'b0, 25);
    chk("t3_last_ch0", rout[0][31:0], 32'h58596263);

    // 4a: frame_start alone mid-row 3 discards the partial frame
    send(0, 10, 10, 0, 34, 0, 1'b0);
    fs[0] = 1'b1;
    idle(1);
    fs[0] = 1'b0;
    idle(2);
    chk("t4a_q", q0.size(), 0);
    frame(0, 10, 10, 0, 1'b0, 25);
    // 4b: frame_start together with the first pixel
    send(0, 10, 10, 0, 23, 0, 1'b0);
    idle(2);
    frame(0, 10, 10, 1, 1'b1, 25);

    // 5: odd size, two frames back to back
    frame(1, 9, 9, 0, 1'b0, 16);
    chk("t5_last_ch0", rout[1][31:0], 32'h42434C4D);
    frame(1, 9, 9, 0, 1'b0, 16);
    chk("t5_last2_ch0", rout[1][31:0], 32'h42434C4D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
